// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   Owns the PC and drives the address of a synchronous-read instruction
//   memory (data returns one clock after the address). Each returned word is
//   tagged with the PC it came from and presented to decode with a valid flag.
//   Decode back-pressure holds the presented word. A downstream-resolved
//   branch/jump redirect kills the presented word and reloads the PC.
//
// Ports
//   i_clk              rising-edge clock
//   i_rst              synchronous active-high reset
//   i_stall            decode cannot accept the presented word
//   i_redirect_valid   one-cycle pulse: taken branch/jump
//   i_redirect_target  new PC when i_redirect_valid
//   o_imem_addr        address to instruction memory (combinational)
//   i_imem_data        memory read data, registered inside the memory
//   o_if_valid         o_if_instr/o_if_pc hold a live instruction
//   o_if_instr         instruction word (passes i_imem_data straight through)
//   o_if_pc            address o_if_instr was fetched from
//   o_fetch_count      accepted instructions, wraps at 2**CNT_W
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                 ADDR_W   = 8,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_target,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [DATA_W-1:0] i_imem_data,
    output logic              o_if_valid,
    output logic [DATA_W-1:0] o_if_instr,
    output logic [ADDR_W-1:0] o_if_pc,
    output logic [CNT_W-1:0]  o_fetch_count
);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_out_pc;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_fetch_count;

    logic              w_hold;
    logic              w_accept;

    // A live word under stall is held by re-reading its own address, so the
    // memory output (and therefore o_if_instr) stays stable without a skid
    // buffer. A redirect in the same cycle overrides the hold.
    assign w_hold   = i_stall & r_out_valid & ~i_redirect_valid;
    assign w_accept = r_out_valid & ~i_stall & ~i_redirect_valid;

    assign o_imem_addr   = w_hold ? r_out_pc : r_fetch_pc;
    assign o_if_valid    = r_out_valid;
    assign o_if_pc       = r_out_pc;
    assign o_if_instr    = i_imem_data;
    assign o_fetch_count = r_fetch_count;

    // Priority: reset, then flush on redirect, then hold, then run. A stall
    // seen while nothing is valid is a bubble and does not hold the pipe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc  <= RESET_PC;
            r_out_pc    <= '0;
            r_out_valid <= 1'b0;
        end else if (i_redirect_valid) begin
            r_fetch_pc  <= i_redirect_target;
            r_out_valid <= 1'b0;
        end else if (!w_hold) begin
            r_out_pc    <= r_fetch_pc;
            r_out_valid <= 1'b1;
            r_fetch_pc  <= r_fetch_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_count <= '0;
        end else if (w_accept) begin
            r_fetch_count <= r_fetch_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed scenarios (reset, stall, redirect, redirect+stall, wrap, reset
//   mid-stall) followed by randomized traffic. A 1-clk registered memory
//   returns word[i] = 32'hA500_0000 | i. Every cycle the outputs are compared
//   to a behavioural model of the fetch stage.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              rv;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic [CNT_W-1:0]  fetch_count;

    int n_chk = 0;
    int n_err = 0;

    // behavioural model: the PC to fetch next, the word on display, the count
    int  m_next;
    int  m_shown;
    bit  m_live;
    int  m_cnt;
    bit  m_known = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= 32'hA500_0000 | 32'(imem_addr);

    instruction_fetch_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(8'd0), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_stall(stall),
        .i_redirect_valid(rv),
        .i_redirect_target(tgt),
        .o_imem_addr(imem_addr),
        .i_imem_data(imem_data),
        .o_if_valid(if_valid),
        .o_if_instr(if_instr),
        .o_if_pc(if_pc),
        .o_fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare mid-cycle against the model, apply the
    // model's update for the coming edge, return just after that edge.
    task automatic cyc(input bit r, input bit s, input bit v, input int t);
        bit held;
        rst   = r;
        stall = s;
        rv    = v;
        tgt   = ADDR_W'(t);
        @(negedge clk);
        if (m_known) begin
            held = s && m_live && !v;
            chk("valid", 64'(if_valid), 64'(m_live));
            chk("count", 64'(fetch_count), 64'(m_cnt));
            chk("addr", 64'(imem_addr), 64'(held ? m_shown : m_next));
            if (m_live) begin
                chk("pc", 64'(if_pc), 64'(m_shown));
                chk("instr", 64'(if_instr), 64'(32'hA500_0000 + m_shown));
            end
        end
        if (r) begin
            m_next = 0; m_shown = 0; m_live = 0; m_cnt = 0; m_known = 1;
        end else begin
            if (m_live && !s && !v) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (v) begin
                m_next = t;
                m_live = 0;
            end else if (!(s && m_live)) begin
                m_shown = m_next;
                m_live  = 1;
                m_next  = (m_next + 1) % (1 << ADDR_W);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_pc(input int pc);
        int budget = 600;
        while (!(if_valid && int'(if_pc) == pc) && budget > 0) begin
            cyc(0, 0, 0, 0);
            budget--;
        end
        chk("reach_pc", 64'(if_pc), 64'(pc));
    endtask

    initial begin
        rst = 1; stall = 0; rv = 0; tgt = '0;
        @(posedge clk);
        #1;

        // T1 reset and first fetches
        repeat (3) cyc(1, 0, 0, 0);
        chk("t1_valid0", 64'(if_valid), 64'd0);
        chk("t1_cnt0", 64'(fetch_count), 64'd0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_pc", 64'(if_pc), 64'(i));
            chk("t1_instr", 64'(if_instr), 64'(32'hA500_0000 + i));
            cyc(0, 0, 0, 0);
        end
        chk("t1_cnt4", 64'(fetch_count), 64'd4);

        // T2 stall while word 5 is presented
        cyc(0, 0, 0, 0);
        chk("t2_pc5", 64'(if_pc), 64'd5);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("t2_hold_pc", 64'(if_pc), 64'd5);
            chk("t2_hold_instr", 64'(if_instr), 64'hA500_0005);
            chk("t2_hold_cnt", 64'(fetch_count), 64'd5);
        end
        cyc(0, 0, 0, 0);
        chk("t2_next", 64'(if_pc), 64'd6);
        chk("t2_cnt", 64'(fetch_count), 64'd6);

        // T3 redirect while word 19 is presented
        run_to_pc(19);
        cyc(0, 0, 1, 22);
        chk("t3_bubble", 64'(if_valid), 64'd0);
        chk("t3_cnt", 64'(fetch_count), 64'd19);
        cyc(0, 0, 0, 0);
        chk("t3_pc", 64'(if_pc), 64'd22);
        chk("t3_instr", 64'(if_instr), 64'hA500_0016);
        cyc(0, 0, 0, 0);
        chk("t3_pc23", 64'(if_pc), 64'd23);

        // T4 redirect and stall together: redirect wins
        cyc(0, 1, 1, 9);
        chk("t4_bubble", 64'(if_valid), 64'd0);
        cyc(0, 0, 0, 0);
        chk("t4_pc", 64'(if_pc), 64'd9);
        chk("t4_valid", 64'(if_valid), 64'd1);

        // T5 wrap at the top of the address space
        cyc(0, 0, 1, 254);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t5_pc", 64'(if_pc), 64'((254 + i) % 256));
            chk("t5_valid", 64'(if_valid), 64'd1);
            cyc(0, 0, 0, 0);
        end

        // T6 reset while stalled on word 40
        cyc(0, 0, 1, 38);
        run_to_pc(40);
        cyc(0, 1, 0, 0);
        chk("t6_pc40", 64'(if_pc), 64'd40);
        cyc(1, 1, 0, 0);
        chk("t6_valid", 64'(if_valid), 64'd0);
        chk("t6_cnt", 64'(fetch_count), 64'd0);
        cyc(0, 0, 0, 0);
        chk("t6_pc0", 64'(if_pc), 64'd0);
        chk("t6_valid1", 64'(if_valid), 64'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(63) == 0,
                $urandom_range(2) == 0,
                $urandom_range(7) == 0,
                int'($urandom_range(255)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
